// File: rtl/channel_pkg.sv
// channel_pkg: types and constants shared by the channel-side blocks.
// Holds the CCW descriptor layout, the command bytes and the sequencer state encoding.
package channel_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_NOP   = 8'h03;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  command;
        logic [15:0] count;
        logic        chain;
    } ccw_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_SETTLE,
        ST_XFER,
        ST_NEXT
    } seq_state_t;

endpackage

// File: rtl/ccw_table.sv
// ccw_table: DEPTH-entry CCW descriptor register file.
// One write port and one registered read port; contents are not reset.
module ccw_table
    import channel_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_index,
    input  ccw_t          i_wr_data,
    input  logic [IW-1:0] i_rd_index,
    output ccw_t          o_rd_data
);

    ccw_t r_mem [DEPTH];
    ccw_t r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_index] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_index];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ccw_sequencer.sv
// ccw_sequencer: runs a chained CCW program through the channel and meters byte counts.
// Chaining to following slots is built only when CCW_SEQUENCER_CHAIN_EN is defined.
module ccw_sequencer
    import channel_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ccw_wr_en,
    input  logic [IW-1:0] ccw_wr_index,
    input  logic [7:0]    ccw_wr_addr,
    input  logic [7:0]    ccw_wr_command,
    input  logic [15:0]   ccw_wr_count,
    input  logic          ccw_wr_chain,
    input  logic          go,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          short,
    output logic [IW-1:0] last_index,
    output logic [15:0]   residual,
    output logic [7:0]    chan_addr,
    output logic [7:0]    chan_command,
    output logic          chan_start,
    output logic          chan_stop,
    input  logic          chan_idle,
    output logic [7:0]    chan_send_tdata,
    output logic          chan_send_tvalid,
    input  logic          chan_send_tready,
    input  logic [7:0]    chan_recv_tdata,
    input  logic          chan_recv_tvalid,
    output logic          chan_recv_tready,
    input  logic [7:0]    src_tdata,
    input  logic          src_tvalid,
    output logic          src_tready,
    output logic [7:0]    sink_tdata,
    output logic          sink_tvalid,
    input  logic          sink_tready
);

    seq_state_t    r_state, w_state_nxt;
    logic [IW-1:0] r_index, w_index_nxt;
    logic [15:0]   r_cnt, w_cnt_nxt;
    logic          r_chain, r_abort_pend, r_stop, r_short;
    logic [7:0]    r_addr, r_cmd;
    logic [15:0]   r_residual;
    logic [IW-1:0] r_last_index;

    ccw_t w_wr_ccw, w_rd_ccw;
    logic w_xfer, w_cnt_nz, w_send_hs, w_recv_hs, w_abort, w_chain_go, w_done;

    assign w_wr_ccw = '{addr: ccw_wr_addr, command: ccw_wr_command,
                        count: ccw_wr_count, chain: ccw_wr_chain};

    // Read index follows the next-state index so the slot is ready during LOAD.
    ccw_table #(.DEPTH(DEPTH)) u_table (
        .clk        (clk),
        .i_wr_en    (ccw_wr_en & (r_state == ST_IDLE)),
        .i_wr_index (ccw_wr_index),
        .i_wr_data  (w_wr_ccw),
        .i_rd_index (w_index_nxt),
        .o_rd_data  (w_rd_ccw)
    );

    assign w_xfer    = (r_state == ST_XFER);
    assign w_cnt_nz  = (r_cnt != '0);
    assign w_send_hs = w_xfer & w_cnt_nz & src_tvalid & chan_send_tready;
    assign w_recv_hs = w_xfer & w_cnt_nz & chan_recv_tvalid & sink_tready;
    assign w_cnt_nxt = (w_send_hs | w_recv_hs) ? r_cnt - 16'd1 : r_cnt;
    assign w_abort   = (r_state != ST_IDLE) & (abort | r_abort_pend);

`ifdef CCW_SEQUENCER_CHAIN_EN
    assign w_chain_go = r_chain & ~r_short & ~w_abort & (r_index != IW'(DEPTH - 1));
`else
    logic w_unused_chain;
    assign w_unused_chain = r_chain;
    assign w_chain_go     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_state_nxt = ST_LOAD;
                    w_index_nxt = '0;
                end
            end
            // An abort before the start pulse skips straight to waiting for idle.
            ST_LOAD:   w_state_nxt = w_abort ? ST_XFER : ST_START;
            ST_START:  w_state_nxt = ST_SETTLE;
            ST_SETTLE: w_state_nxt = ST_XFER;
            ST_XFER: begin
                if (chan_idle) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (w_chain_go) begin
                    w_state_nxt = ST_LOAD;
                    w_index_nxt = r_index + IW'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_cnt        <= '0;
            r_chain      <= 1'b0;
            r_abort_pend <= 1'b0;
            r_stop       <= 1'b0;
            r_addr       <= '0;
            r_cmd        <= '0;
            r_short      <= 1'b0;
            r_residual   <= '0;
            r_last_index <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_cnt        <= w_cnt_nxt;
            r_abort_pend <= w_abort & (w_state_nxt != ST_IDLE);
            // Stop is never raised once the channel reports idle.
            r_stop       <= w_xfer & ~chan_idle &
                            (w_abort | (~w_cnt_nz & (chan_send_tready | chan_recv_tvalid)));
            if (r_state == ST_LOAD) begin
                r_addr  <= w_rd_ccw.addr;
                r_cmd   <= w_rd_ccw.command;
                r_cnt   <= w_rd_ccw.count;
                r_chain <= w_rd_ccw.chain;
            end
            if (w_xfer & chan_idle) begin
                r_residual   <= w_cnt_nxt;
                r_short      <= (w_cnt_nxt != '0);
                r_last_index <= r_index;
            end
        end
    end

    assign busy             = (r_state != ST_IDLE) & ~w_done;
    assign done             = w_done;
    assign short            = r_short;
    assign last_index       = r_last_index;
    assign residual         = r_residual;
    assign chan_addr        = r_addr;
    assign chan_command     = r_cmd;
    assign chan_start       = (r_state == ST_START);
    assign chan_stop        = r_stop;
    assign chan_send_tdata  = w_xfer ? src_tdata : '0;
    assign chan_send_tvalid = w_xfer & w_cnt_nz & src_tvalid;
    assign src_tready       = w_xfer & w_cnt_nz & chan_send_tready;
    assign sink_tdata       = w_xfer ? chan_recv_tdata : '0;
    assign sink_tvalid      = w_xfer & w_cnt_nz & chan_recv_tvalid;
    assign chan_recv_tready = w_xfer & w_cnt_nz & sink_tready;

endmodule

// File: tb/tb_ccw_sequencer.sv
// tb_ccw_sequencer: randomized channel/host traffic against a program-level model.
// Honors CCW_SEQUENCER_CHAIN_EN the same way as the design.
module tb_ccw_sequencer;
    import channel_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = $clog2(DEPTH);
`ifdef CCW_SEQUENCER_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ccw_wr_en, ccw_wr_chain, go, abort;
    logic [IW-1:0] ccw_wr_index;
    logic [7:0]    ccw_wr_addr, ccw_wr_command;
    logic [15:0]   ccw_wr_count;
    logic          busy, done, short;
    logic [IW-1:0] last_index;
    logic [15:0]   residual;
    logic [7:0]    chan_addr, chan_command;
    logic          chan_start, chan_stop, chan_idle;
    logic [7:0]    chan_send_tdata, chan_recv_tdata, src_tdata, sink_tdata;
    logic          chan_send_tvalid, chan_send_tready, chan_recv_tvalid, chan_recv_tready;
    logic          src_tvalid, src_tready, sink_tvalid, sink_tready;

    always #5 clk = ~clk;

    ccw_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ccw_wr_en(ccw_wr_en), .ccw_wr_index(ccw_wr_index), .ccw_wr_addr(ccw_wr_addr),
        .ccw_wr_command(ccw_wr_command), .ccw_wr_count(ccw_wr_count), .ccw_wr_chain(ccw_wr_chain),
        .go(go), .abort(abort), .busy(busy), .done(done), .short(short),
        .last_index(last_index), .residual(residual),
        .chan_addr(chan_addr), .chan_command(chan_command),
        .chan_start(chan_start), .chan_stop(chan_stop), .chan_idle(chan_idle),
        .chan_send_tdata(chan_send_tdata), .chan_send_tvalid(chan_send_tvalid),
        .chan_send_tready(chan_send_tready),
        .chan_recv_tdata(chan_recv_tdata), .chan_recv_tvalid(chan_recv_tvalid),
        .chan_recv_tready(chan_recv_tready),
        .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
        .sink_tdata(sink_tdata), .sink_tvalid(sink_tvalid), .sink_tready(sink_tready)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  cmd;
        logic [15:0] count;
        logic        chain;
    } desc_t;

    // Channel-side behaviour for the k-th started CCW of a program.
    typedef struct {
        bit present;
        int left;
        bit hold;
        int stop_need;
    } cu_t;

    desc_t tbl    [DEPTH];
    cu_t   cu_cfg [DEPTH];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ccw_wr_en = 1'b0; go = 1'b0; abort = 1'b0;
        chan_idle = 1'b1; chan_send_tready = 1'b0; chan_recv_tvalid = 1'b0;
        chan_recv_tdata = '0; src_tvalid = 1'b0; src_tdata = '0; sink_tready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_status"}, 32'({busy, done, short, last_index, residual}), 32'd0);
        check_eq({tag, "_chan"}, 32'({chan_addr, chan_command, chan_start, chan_stop}), 32'd0);
        check_eq({tag, "_stream"}, 32'({chan_send_tdata, chan_send_tvalid, chan_recv_tready,
                                        src_tready, sink_tdata, sink_tvalid}), 32'd0);
    endtask

    task automatic write_slot(input int idx, input logic [7:0] a, input logic [7:0] c,
                              input logic [15:0] n, input logic ch);
        ccw_wr_en = 1'b1; ccw_wr_index = IW'(idx);
        ccw_wr_addr = a; ccw_wr_command = c; ccw_wr_count = n; ccw_wr_chain = ch;
        @(posedge clk); #1;
        ccw_wr_en = 1'b0;
        tbl[idx].addr = a; tbl[idx].cmd = c; tbl[idx].count = n; tbl[idx].chain = ch;
    endtask

    // Program-level outcome: walk the slots, each moves min(count, CU supply) bytes.
    task automatic model(input bit aborting, output int n_start, output int e_last,
                         output int e_resid, output bit e_short, output int n_stop,
                         output int n_src, output int n_sink);
        int i = 0;
        int t;
        n_start = 0; n_stop = 0; n_src = 0; n_sink = 0;
        e_last = 0; e_resid = 0; e_short = 1'b0;
        forever begin
            t = 0;
            if (cu_cfg[i].present)
                t = (cu_cfg[i].left < int'(tbl[i].count)) ? cu_cfg[i].left : int'(tbl[i].count);
            n_start++;
            e_last  = i;
            e_resid = int'(tbl[i].count) - t;
            e_short = (e_resid != 0);
            if (tbl[i].cmd == CMD_WRITE) n_src += t;
            if (tbl[i].cmd == CMD_READ)  n_sink += t;
            if (cu_cfg[i].present && (aborting || cu_cfg[i].left > int'(tbl[i].count)))
                n_stop += cu_cfg[i].stop_need;
            if (!CHAIN_EN || aborting || !tbl[i].chain || e_short || i == int'(DEPTH) - 1)
                break;
            i++;
        end
    endtask

    task automatic run_program(input string name, input bit do_abort, input bit poke,
                               input int reset_at);
        int  e_start, e_last, e_resid, e_stop, e_src, e_sink;
        bit  e_short;
        int  starts = 0, stops = 0, n_src = 0, n_sink = 0, c = 0;
        int  g_last = 0, g_resid = 0;
        bit  g_short = 1'b0, done_seen = 1'b0, aborted = 1'b0, was_reset = 1'b0;
        bit  cu_active = 1'b0, cu_hold = 1'b0;
        int  cu_left = 0, cu_stops = 0, cu_need = 1;
        logic [7:0] cu_mode = '0;

        model(do_abort, e_start, e_last, e_resid, e_short, e_stop, e_src, e_sink);
        while (!done_seen && c < 400) begin
            if (cu_active && chan_stop) begin
                cu_stops++;
                if (cu_stops >= cu_need) cu_active = 1'b0;
            end
            if (cu_active && cu_left == 0 && !cu_hold) cu_active = 1'b0;
            go        = (c == 0) || (poke && c == 5);
            ccw_wr_en = poke && c == 5;
            ccw_wr_index = '0; ccw_wr_addr = 8'h55; ccw_wr_command = CMD_NOP;
            ccw_wr_count = 16'd0; ccw_wr_chain = 1'b0;
            abort = 1'b0;
            if (do_abort && !aborted && cu_active && cu_hold && cu_left == 0) begin
                abort = 1'b1; aborted = 1'b1;
            end
            reset = (c != reset_at);
            chan_idle = !cu_active;
            chan_recv_tvalid = 1'b0; chan_send_tready = 1'b0;
            chan_recv_tdata  = 8'($urandom);
            if (cu_active) begin
                if (cu_mode == CMD_READ)
                    chan_recv_tvalid = (cu_left > 0) && ($urandom % 4 != 0);
                else if (cu_mode == CMD_WRITE)
                    chan_send_tready = (cu_left > 0) && ($urandom % 4 != 0);
                else
                    chan_send_tready = 1'b1;
            end
            src_tvalid  = ($urandom % 4 != 0);
            src_tdata   = 8'($urandom);
            sink_tready = ($urandom % 4 != 0);

            @(negedge clk);
            if (chan_start) begin
                if (starts == 0) check_eq({name, "_go_to_start"}, 32'(c), 32'd2);
                if (starts < int'(DEPTH)) begin
                    check_eq({name, "_addr"}, 32'(chan_addr), 32'(tbl[starts].addr));
                    check_eq({name, "_cmd"}, 32'(chan_command), 32'(tbl[starts].cmd));
                    cu_active = cu_cfg[starts].present;
                    cu_left   = cu_cfg[starts].left;
                    cu_hold   = cu_cfg[starts].hold;
                    cu_need   = cu_cfg[starts].stop_need;
                    cu_stops  = 0;
                    cu_mode   = chan_command;
                end
                starts++;
            end
            if (chan_recv_tvalid && chan_recv_tready) cu_left--;
            if (chan_send_tvalid && chan_send_tready) begin
                cu_left--;
                check_eq({name, "_send_data"}, 32'(chan_send_tdata), 32'(src_tdata));
            end
            if (sink_tvalid && sink_tready) begin
                n_sink++;
                check_eq({name, "_sink_data"}, 32'(sink_tdata), 32'(chan_recv_tdata));
            end
            if (src_tvalid && src_tready) n_src++;
            if (chan_stop) stops++;
            if (done) begin
                done_seen = 1'b1;
                g_last = int'(last_index); g_resid = int'(residual); g_short = short;
                check_eq({name, "_busy_at_done"}, 32'(busy), 32'd0);
            end
            @(posedge clk); #1;
            if (c == reset_at) begin
                check_all_zero({name, "_rst"});
                was_reset = 1'b1;
                break;
            end
            c++;
        end
        idle_inputs();
        reset = 1'b1;
        if (was_reset) begin
            for (int k = 0; k < 4; k++) begin
                check_eq({name, "_no_done_after_rst"}, 32'({done, busy}), 32'd0);
                @(posedge clk); #1;
            end
        end else begin
            check_eq({name, "_done_seen"}, 32'(done_seen), 32'd1);
            check_eq({name, "_starts"}, 32'(starts), 32'(e_start));
            check_eq({name, "_stops"}, 32'(stops), 32'(e_stop));
            check_eq({name, "_src_bytes"}, 32'(n_src), 32'(e_src));
            check_eq({name, "_sink_bytes"}, 32'(n_sink), 32'(e_sink));
            check_eq({name, "_last_index"}, 32'(g_last), 32'(e_last));
            check_eq({name, "_residual"}, 32'(g_resid), 32'(e_resid));
            check_eq({name, "_short"}, 32'(g_short), 32'(e_short));
            @(posedge clk); #1;
            check_eq({name, "_held"}, 32'({busy, short, residual}), 32'({1'b0, e_short, 16'(e_resid)}));
        end
    endtask

    task automatic set_cu(input int k, input bit p, input int l, input bit h, input int s);
        cu_cfg[k].present = p; cu_cfg[k].left = l; cu_cfg[k].hold = h; cu_cfg[k].stop_need = s;
    endtask

    initial begin
        idle_inputs();
        ccw_wr_index = '0; ccw_wr_addr = '0; ccw_wr_command = '0;
        ccw_wr_count = '0; ccw_wr_chain = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) set_cu(k, 1'b1, 0, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        write_slot(0, 8'h1a, CMD_READ, 16'd6, 1'b0);
        set_cu(0, 1'b1, 16, 1'b0, 1);
        run_program("single_read", 1'b0, 1'b0, -1);

        write_slot(0, 8'h1a, CMD_READ, 16'd16, 1'b0);
        set_cu(0, 1'b1, 6, 1'b0, 1);
        run_program("short_read", 1'b0, 1'b0, -1);

        write_slot(0, 8'h1a, CMD_WRITE, 16'd4, 1'b1);
        write_slot(1, 8'h1a, CMD_READ, 16'd3, 1'b0);
        set_cu(0, 1'b1, 4, 1'b0, 1);
        set_cu(1, 1'b1, 10, 1'b0, 1);
        run_program("chain_wr_rd", 1'b0, 1'b0, -1);

        write_slot(0, 8'h1a, CMD_NOP, 16'd0, 1'b0);
        set_cu(0, 1'b1, 100, 1'b0, 1);
        run_program("nop", 1'b0, 1'b0, -1);

        write_slot(0, 8'h10, CMD_READ, 16'd6, 1'b1);
        set_cu(0, 1'b0, 0, 1'b0, 1);
        run_program("no_cu", 1'b0, 1'b0, -1);

        write_slot(0, 8'h1a, CMD_READ, 16'd6, 1'b1);
        write_slot(1, 8'h1b, CMD_READ, 16'd2, 1'b0);
        set_cu(0, 1'b1, 2, 1'b1, 3);
        set_cu(1, 1'b1, 5, 1'b0, 1);
        run_program("abort", 1'b1, 1'b1, -1);

        // Slot 0 must still hold 1a/READ: the write issued while busy is dropped.
        set_cu(0, 1'b1, 16, 1'b0, 1);
        run_program("after_busy_wr", 1'b0, 1'b0, -1);

        for (int k = 0; k < int'(DEPTH); k++) begin
            write_slot(k, 8'(8'h20 + k), (k % 2 == 0) ? CMD_READ : CMD_WRITE, 16'(k + 1), 1'b1);
            set_cu(k, 1'b1, k + 1, 1'b0, 1);
        end
        run_program("full_depth", 1'b0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                write_slot(k, 8'($urandom), ($urandom % 2 == 0) ? CMD_READ : CMD_WRITE,
                           16'($urandom_range(0, 8)), ($urandom % 4 != 0));
                set_cu(k, ($urandom % 5 != 0), int'($urandom_range(0, 10)), 1'b0, 1);
            end
            run_program($sformatf("rand%0d", r), 1'b0, 1'b0, -1);
        end

        write_slot(0, 8'h1a, CMD_READ, 16'd16, 1'b0);
        set_cu(0, 1'b1, 4, 1'b0, 1);
        run_program("pre_reset", 1'b0, 1'b0, -1);
        write_slot(0, 8'h1a, CMD_READ, 16'd6, 1'b0);
        set_cu(0, 1'b1, 16, 1'b0, 1);
        run_program("reset_mid", 1'b0, 1'b0, 6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ccw_sequencer.md
# ccw_sequencer

Sequences a short channel program of chained CCWs through the `channel` block. It stores up to `DEPTH` CCW descriptors and issues each one to the channel as address, command and start. It meters data bytes between the host-side streams and the channel data ports against each CCW's count, and issues `stop` when the count is exhausted. It sits between the host/control logic and `channel`, and replaces ad-hoc count/stop logic in front of the channel.

## Interface

Parameters:
- `DEPTH`, default 4: number of CCW slots (power of two, ≥2). `IW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `ccw_wr_en`  in  1  write descriptor slot (ignored while `busy`)
- `ccw_wr_index`  in  IW  slot to write
- `ccw_wr_addr` / `ccw_wr_command`  in  8 / 8  device address, command byte
- `ccw_wr_count`  in  16  byte count
- `ccw_wr_chain`  in  1  chain to next slot
- `go`  in  1  start program at slot 0 (IDLE only)
- `abort`  in  1  terminate program
- `busy`  out  1  program in progress
- `done`  out  1  one-cycle pulse at program end
- `short`  out  1  last CCW ended with nonzero residual; valid with `done`, held
- `last_index`  out  IW  slot of last executed CCW; held
- `residual`  out  16  remaining count of last executed CCW; held
- `chan_addr` / `chan_command`  out  8 / 8  to channel
- `chan_start` / `chan_stop`  out  1  to channel
- `chan_idle`  in  1  channel FSM is in IDLE
- `chan_send_tdata`  out  8; `chan_send_tvalid`  out  1; `chan_send_tready`  in  1
- `chan_recv_tdata`  in  8; `chan_recv_tvalid`  in  1; `chan_recv_tready`  out  1
- `src_tdata`  in  8; `src_tvalid`  in  1; `src_tready`  out  1  (write data from host)
- `sink_tdata`  out  8; `sink_tvalid`  out  1; `sink_tready`  in  1  (read data to host)

## Operation

- **Reset values:** all outputs 0, including `busy`, `done`, `short`, `residual`, `last_index`, `chan_*` and the stream valid/ready signals. Descriptor table contents are not reset.
- **FSM:** IDLE → LOAD → START → SETTLE → XFER → NEXT → (LOAD | IDLE).
  - **IDLE:** `go` → LOAD with slot index 0, `busy`=1.
  - **LOAD:** registers slot into `chan_addr`, `chan_command` and the count register.
  - **START:** `chan_start`=1 for exactly one cycle.
  - **SETTLE:** one cycle; `chan_idle` is ignored.
  - **XFER:** runs until `chan_idle`=1.
    - Send path: `chan_send_tvalid = src_tvalid & cnt≠0`; `src_tready = chan_send_tready & cnt≠0`; `chan_send_tdata = src_tdata`.
    - Receive path: `sink_tvalid = chan_recv_tvalid & cnt≠0`; `chan_recv_tready = sink_tready & cnt≠0`.
    - Either handshake decrements `cnt`. Both paths in the same cycle decrement `cnt` by 1 only; not expected from the channel.
    - `cnt==0` with `chan_send_tready` or `chan_recv_tvalid` high → `chan_stop`=1 for one cycle, repeated every such cycle.
  - **NEXT:** latches `residual=cnt`, `last_index`, `short=(cnt≠0)`.
    - If chain is set, `short`=0, and the index is not DEPTH−1: index+1 → LOAD.
    - Otherwise: `done` pulse, `busy`=0 → IDLE.
- **Count:** 16-bit unsigned, never wraps below 0. A count of 0 is legal (e.g. NOP): any data request is answered with `stop`.
- **Short CCW** (CU ends before count reaches 0): chain is broken, `short`=1.
- **`abort`** in any non-IDLE state: `chan_stop` asserted on every cycle until `chan_idle` is seen, then NEXT with chaining suppressed. `short` reflects `cnt`.
- `go` while `busy` is ignored. `ccw_wr_en` while `busy` is ignored.
- Reset mid-program returns to IDLE immediately, with no `done` pulse.

## Timing

- `go` at cycle 0 → LOAD cycle 1 → `chan_start` cycle 2. `chan_addr`/`chan_command` are valid from cycle 2 and stable until NEXT.
- Data paths are combinational through the block: zero added latency, one byte per cycle maximum.
- `chan_idle` high in XFER at cycle n → NEXT at n+1 → `chan_start` of the next CCW at n+3, or `done` at n+1.
- `chan_stop` is registered: it is asserted the cycle after the data request is sampled with `cnt==0`.

## Configuration

- `CCW_SEQUENCER_CHAIN_EN`:
  - Defined: chaining as above.
  - Undefined: `ccw_wr_chain` is ignored; each `go` executes slot 0 only; `last_index` is always 0. Table storage for slots 1..DEPTH−1 remains writable but unused.

## Structure

- Shared package `channel_pkg`:
  - CCW descriptor struct (`addr`, `command`, `count`, `chain`)
  - command constants: WRITE 8'h01, READ 8'h02, NOP 8'h03
  - sequencer state enum
- One sub-module, `ccw_table`: DEPTH-entry register file with one write port and one registered read port, used by LOAD.

## Test plan

- **Single READ:** slot0 = {1a, 02, 6, chain=0}, CU supplies 16 → 6 bytes on sink, `chan_stop` once, `done`, `residual`=0, `short`=0.
- **Short READ:** count 16, CU supplies 6 → 6 sink bytes, `done`, `residual`=10, `short`=1.
- **Chain WRITE→READ:** slot0 = {1a, 01, 4, chain=1}, slot1 = {1a, 02, 3, chain=0} → 4 src bytes consumed then 3 sink bytes, two `chan_start` pulses, `last_index`=1, `residual`=0. Without the macro: one `chan_start`, `last_index`=0.
- **NOP count 0:** slot0 = {1a, 03, 0} → no stream handshakes, `done`, `residual`=0; any data request answered with `chan_stop`.
- **No CU / busy CU:** addr 10 → channel returns idle, `done`, `residual`=6, `short`=1, chain not followed.
- **Abort mid-READ:** after 2 of 6 bytes, `abort` → `chan_stop` held until `chan_idle`, `done`, `residual`=4; `go` during busy ignored; reset mid-XFER → all outputs 0 next cycle.
